mem_access_unit: RTL and testbench

Data-memory access unit for the MEM stage of the pipelined MIPS core. Consumes the `MemControl` code, effective address and store data produced by decode/EX, and drives a word-wide external data bus with a request/grant/read-valid handshake. It applies byte enables and lane steering for stores, and sign- or zero-extends load data. It stalls the pipeline until each access completes and flags misaligned or timed-out accesses.

---
 rtl/mem_access_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: request/grant/rvalid bus master with byte-lane
// steering, load extension, misalignment detection and an access timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [3:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [3:0] CtrlLw  = 4'd1;
    localparam logic [3:0] CtrlLh  = 4'd2;
    localparam logic [3:0] CtrlLhu = 4'd3;
    localparam logic [3:0] CtrlLb  = 4'd4;
    localparam logic [3:0] CtrlLbu = 4'd5;
    localparam logic [3:0] CtrlSw  = 4'd6;
    localparam logic [3:0] CtrlSh  = 4'd7;
    localparam logic [3:0] CtrlSb  = 4'd8;

    // Counter value seen in the last permitted waiting cycle.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRdWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [1:0]  lane_q, lane_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdat_q, wdat_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aerr_q, aerr_d;
    logic        berr_q, berr_d;

    logic        is_word, is_half, is_byte, is_store;
    logic        accept, misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdat_new;

    always_comb begin
        is_word  = 1'b0;
        is_half  = 1'b0;
        is_byte  = 1'b0;
        is_store = 1'b0;
        wdat_new = 32'h0;
        case (mem_ctrl)
            CtrlLw:          is_word = 1'b1;
            CtrlLh, CtrlLhu: is_half = 1'b1;
            CtrlLb, CtrlLbu: is_byte = 1'b1;
            CtrlSw: begin
                is_word  = 1'b1;
                is_store = 1'b1;
                wdat_new = wdata;
            end
            CtrlSh: begin
                is_half  = 1'b1;
                is_store = 1'b1;
                wdat_new = {2{wdata[15:0]}};
            end
            CtrlSb: begin
                is_byte  = 1'b1;
                is_store = 1'b1;
                wdat_new = {4{wdata[7:0]}};
            end
            default: ;
        endcase

        misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        // Gated by reset so stall reads 0 while reset is held.
        accept = rst_n & op_valid & (is_word | is_half | is_byte);

        if (is_word) begin
            be_new = 4'b1111;
        end else if (is_half) begin
            be_new = addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            be_new = 4'b0001 << addr[1:0];
        end
    end

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (ctrl_q)
            CtrlLb:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            CtrlLbu: load_ext = {24'h0, rd_byte};
            CtrlLh:  load_ext = {{16{rd_half[15]}}, rd_half};
            CtrlLhu: load_ext = {16'h0, rd_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        lane_d  = lane_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        aerr_d  = aerr_q;
        berr_d  = berr_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    ctrl_d  = mem_ctrl;
                    lane_d  = addr[1:0];
                    waddr_d = addr[31:2];
                    be_d    = be_new;
                    wdat_d  = wdat_new;
                    we_d    = is_store;
                    aerr_d  = misaligned;
                    berr_d  = 1'b0;
                    cnt_d   = 8'h0;
                    if (misaligned) begin
                        rdata_d = 32'h0;
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_gnt) begin
                    if (we_q) begin
                        rdata_d = 32'h0;
                        state_d = StDone;
                    end else begin
                        state_d = StRdWait;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    berr_d  = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StDone;
                end
            end
            StRdWait: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    rdata_d = load_ext;
                    state_d = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    berr_d  = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ctrl_q  <= 4'h0;
            lane_q  <= 2'h0;
            waddr_q <= 30'h0;
            be_q    <= 4'h0;
            wdat_q  <= 32'h0;
            we_q    <= 1'b0;
            cnt_q   <= 8'h0;
            rdata_q <= 32'h0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            lane_q  <= lane_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    // Bus fields are only driven while requesting, so aborted or misaligned
    // stores never expose their data.
    always_comb begin
        stall     = (state_q == StIdle && accept) || state_q == StReq || state_q == StRdWait;
        done      = (state_q == StDone);
        rdata     = rdata_q;
        addr_err  = done & aerr_q;
        bus_err   = done & berr_q;
        bus_req   = (state_q == StReq);
        bus_we    = bus_req & we_q;
        bus_addr  = bus_req ? {waddr_q, 2'b00} : 32'h0;
        bus_be    = bus_req ? be_q : 4'h0;
        bus_wdata = bus_req ? wdat_q : 32'h0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with a simple grant/rvalid responder.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  mem_ctrl = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    logic        stall, done, addr_err, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .mem_ctrl   (mem_ctrl),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .addr_err   (addr_err),
        .bus_err    (bus_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] rd;
        logic        aerr;
        int          lat;
        int          nreq;
    } vec_t;

    vec_t vecs[12];

    // Drives one access, grants in the first REQ cycle (unless no_gnt) and
    // returns rvalid one cycle after the grant.
    task automatic run(input vec_t v, input logic no_gnt, output int lat, output int nreq,
                       output int nstall, output logic [31:0] got_rd, output logic got_aerr,
                       output logic got_berr, output logic we, output logic [31:0] baddr,
                       output logic [3:0] be, output logic [31:0] bwd);
        logic granted;
        granted = 1'b0;
        lat = 0; nreq = 0; got_rd = 32'h0; got_aerr = 1'b0; got_berr = 1'b0;
        we = 1'b0; baddr = 32'h0; be = 4'h0; bwd = 32'h0;
        @(negedge clk);
        op_valid = 1'b1; mem_ctrl = v.ctrl; addr = v.addr; wdata = v.wdata;
        #1;
        nstall = stall ? 1 : 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            op_valid = 1'b0; mem_ctrl = 4'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (granted) begin
                bus_rvalid = 1'b1;
                bus_rdata  = v.brd;
            end
            granted = 1'b0;
            #1;
            if (stall) nstall++;
            if (bus_req) begin
                nreq++;
                we = bus_we; baddr = bus_addr; be = bus_be; bwd = bus_wdata;
                if (!no_gnt) begin
                    bus_gnt = 1'b1;
                    granted = 1'b1;
                end
            end
            if (done) begin
                lat = c; got_rd = rdata; got_aerr = addr_err; got_berr = bus_err;
                break;
            end
        end
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    int          lat, nreq, nstall;
    logic [31:0] got_rd, baddr, bwd;
    logic        got_aerr, got_berr, we;
    logic [3:0]  be;
    vec_t        tv;
    int          n_done, n_req, n_stall;

    initial begin
        vecs[0]  = '{4'd6, 32'h100, 32'hDEADBEEF, 32'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1};
        vecs[1]  = '{4'd4, 32'h203, 32'h0, 32'h80FF0000, 4'h8, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1};
        vecs[2]  = '{4'd5, 32'h203, 32'h0, 32'h80FF0000, 4'h8, 32'h0, 32'h00000080, 1'b0, 3, 1};
        vecs[3]  = '{4'd7, 32'h002, 32'h1234, 32'h0, 4'hC, 32'h12341234, 32'h0, 1'b0, 2, 1};
        vecs[4]  = '{4'd2, 32'h001, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0};
        vecs[5]  = '{4'd2, 32'h002, 32'h0, 32'h80017FFF, 4'hC, 32'h0, 32'hFFFF8001, 1'b0, 3, 1};
        vecs[6]  = '{4'd3, 32'h000, 32'h0, 32'h1234ABCD, 4'h3, 32'h0, 32'h0000ABCD, 1'b0, 3, 1};
        vecs[7]  = '{4'd1, 32'h104, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1};
        vecs[8]  = '{4'd8, 32'h001, 32'hA5, 32'h0, 4'h2, 32'hA5A5A5A5, 32'h0, 1'b0, 2, 1};
        vecs[9]  = '{4'd6, 32'h102, 32'h11223344, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0};
        vecs[10] = '{4'd4, 32'h001, 32'h0, 32'h00007F00, 4'h2, 32'h0, 32'h0000007F, 1'b0, 3, 1};
        vecs[11] = '{4'd3, 32'h003, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1, 0};

        // Reset state
        #1;
        chk("reset outputs", {stall, done, rdata, addr_err, bus_err, bus_req, bus_we,
                              bus_addr, bus_be, bus_wdata}, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run(vecs[i], 1'b0, lat, nreq, nstall, got_rd, got_aerr, got_berr, we, baddr, be, bwd);
            chk($sformatf("v%0d latency", i), 128'(lat), 128'(vecs[i].lat));
            chk($sformatf("v%0d req cycles", i), 128'(nreq), 128'(vecs[i].nreq));
            chk($sformatf("v%0d stall cycles", i), 128'(nstall), 128'(vecs[i].lat));
            chk($sformatf("v%0d addr_err", i), 128'(got_aerr), 128'(vecs[i].aerr));
            chk($sformatf("v%0d bus_err", i), 128'(got_berr), 128'h0);
            if (vecs[i].ctrl < 4'd6 || vecs[i].aerr)
                chk($sformatf("v%0d rdata", i), 128'(got_rd), 128'(vecs[i].rd));
            if (vecs[i].nreq > 0) begin
                chk($sformatf("v%0d bus_we", i), 128'(we), 128'(vecs[i].ctrl >= 4'd6));
                chk($sformatf("v%0d bus_addr", i), 128'(baddr), 128'({vecs[i].addr[31:2], 2'b00}));
                chk($sformatf("v%0d bus_be", i), 128'(be), 128'(vecs[i].be));
                if (vecs[i].ctrl >= 4'd6)
                    chk($sformatf("v%0d bus_wdata", i), 128'(bwd), 128'(vecs[i].bwd));
            end
        end

        // Timeout: LW never granted, TIMEOUT=4
        run(vecs[7], 1'b0, lat, nreq, nstall, got_rd, got_aerr, got_berr, we, baddr, be, bwd);
        chk("pre-timeout LW rdata", 128'(got_rd), 128'hCAFEF00D);
        tv = '{4'd1, 32'h200, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0, 5, 4};
        run(tv, 1'b1, lat, nreq, nstall, got_rd, got_aerr, got_berr, we, baddr, be, bwd);
        chk("timeout latency", 128'(lat), 128'd5);
        chk("timeout req cycles", 128'(nreq), 128'd4);
        chk("timeout stall cycles", 128'(nstall), 128'd5);
        chk("timeout bus_err", 128'(got_berr), 128'h1);
        chk("timeout addr_err", 128'(got_aerr), 128'h0);
        chk("timeout rdata", 128'(got_rd), 128'h0);
        run(vecs[1], 1'b0, lat, nreq, nstall, got_rd, got_aerr, got_berr, we, baddr, be, bwd);
        chk("after timeout latency", 128'(lat), 128'd3);
        chk("after timeout rdata", 128'(got_rd), 128'hFFFFFF80);
        chk("after timeout bus_err", 128'(got_berr), 128'h0);

        // Reset while in RD_WAIT
        @(negedge clk);
        op_valid = 1'b1; mem_ctrl = 4'd1; addr = 32'h300;
        @(negedge clk);
        op_valid = 1'b0; mem_ctrl = 4'h0;
        #1;
        chk("rst seq in REQ", 128'(bus_req), 128'h1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        chk("rst seq in RD_WAIT", 128'({bus_req, stall}), 128'h1);
        rst_n = 1'b0;
        #1;
        chk("mid-op reset outputs", {stall, done, rdata, addr_err, bus_err, bus_req, bus_we,
                                     bus_addr, bus_be, bus_wdata}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h12345678;
        n_done = 0; n_req = 0; n_stall = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (done) n_done++;
            if (bus_req) n_req++;
            if (stall) n_stall++;
            @(negedge clk);
        end
        bus_rvalid = 1'b0;
        chk("post-reset done", 128'(n_done), 128'h0);
        chk("post-reset activity", 128'({n_req, n_stall}), 128'h0);
        chk("post-reset rdata", 128'(rdata), 128'h0);

        // op_valid=0 with LW, then a reserved code
        op_valid = 1'b0; mem_ctrl = 4'd1; addr = 32'h100;
        #1;
        chk("invalid LW stall", 128'(stall), 128'h0);
        n_done = 0; n_req = 0; n_stall = 0;
        @(negedge clk);
        op_valid = 1'b1; mem_ctrl = 4'd12;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (done) n_done++;
            if (bus_req) n_req++;
            if (stall) n_stall++;
            @(negedge clk);
        end
        op_valid = 1'b0; mem_ctrl = 4'h0;
        chk("nop bus_req", 128'(n_req), 128'h0);
        chk("nop stall", 128'(n_stall), 128'h0);
        chk("nop done", 128'(n_done), 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
